hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline sequencing controller for the 8-bit four-stage-after-fetch RISC core (IF, ID, EX, MEM, WB). It tracks the destination register of every in-flight instruction, stalls on load-use hazards, and squashes on taken branches. It also freezes the whole pipeline while data memory is busy, and produces registered operand-forwarding selects for the EX stage. It sits beside the ID-stage decoder and drives the PC, IF/ID and ID/EX register enables.

## Interface
Parameters:
- REG_AW, 4, register address width (16 architectural registers, none hardwired)
- OPC_W, 4, opcode width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  OPC_W  opcode of instruction in ID
- id_rd, id_rs1, id_rs2  in  REG_AW each  register fields of instruction in ID
- ex_branch_taken  in  1  BEQ in EX resolved taken this cycle
- dmem_busy  in  1  data memory not ready; pipeline must freeze
- pc_hold  out  1  hold PC
- ifid_hold  out  1  hold IF/ID register
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP into ID/EX
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- stall_cnt, flush_cnt  out  16 each  performance counters (only with HAZARD_PERF_CNT_EN)

## Operation
- Internal decode of id_opcode:
  - regwrite for 0–5, 7, 9–E; memread for 5.
  - Reads rs1 and rs2: 0–3, 6, 7, 8, C–E.
  - Reads rs1 only: 4, 5, 9. Reads rs2 only: A, B. F reads nothing.
- Scoreboard: entries EX, MEM, WB, each {valid, rd, regwrite, memread}.
  - On advance: WB←MEM, MEM←EX, EX←ID-decoded entry.
  - EX←invalid entry when a bubble or flush is inserted.
- Hazard evaluation each cycle, in priority order:
  1. Freeze: dmem_busy=1. pc_hold=ifid_hold=1, no bubble, no flush, scoreboard and fwd regs hold.
  2. Branch squash: ex_branch_taken=1 and not frozen. ifid_flush=1, idex_bubble=1, PC loads the branch target (holds low). Suppresses any simultaneous load-use stall.
  3. Load-use: EX entry is valid, memread, rd≠–, and a source actually read by the id_valid instruction equals EX.rd. pc_hold=ifid_hold=1, idex_bubble=1.
  4. Otherwise: all controls 0, normal advance.
- Forwarding, computed from the ID instruction and registered into fwd_a/fwd_b on advance:
  - A source matching a valid regwrite EX entry gets 01 (that entry will be in MEM).
  - Else a source matching a valid regwrite MEM entry gets 10.
  - Else 00. Youngest producer wins.
  - An unread source always gets 00.
- Bubble or flush cycle: fwd regs load 00.

## Timing
- Reset (async assert, sync release): scoreboard entries invalid; fwd_a=fwd_b=00; counters 0.
- Outputs during reset: pc_hold, ifid_hold, ifid_flush and idex_bubble are combinational and read 0 because the scoreboard is empty.
- Control outputs are combinational from inputs plus scoreboard, with no added latency. fwd_* are registered and valid in the cycle the instruction occupies EX.
- A load-use stall costs exactly 1 cycle. A taken branch costs 2 squashed slots. Freeze lasts for as long as dmem_busy is high.
- dmem_busy together with ex_branch_taken: freeze wins. The branch is re-evaluated after the freeze because EX holds.
- Reset mid-operation clears everything immediately. The first post-reset cycle is treated as an empty pipeline.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each branch squash.
  - Both saturate at 16'hFFFF and do not count during freeze.
- Undefined: counter logic is absent and stall_cnt/flush_cnt are tied to 0.

## Structure
- Shared package risc8_pkg holds:
  - opcode localparams (OP_ADD…OP_NOP)
  - fwd encodings FWD_RF/FWD_EXMEM/FWD_MEMWB
  - scoreboard entry struct/typedef
  - opcode-class decode function (regwrite, memread, reads_rs1, reads_rs2)
- One sub-module, hazard_scoreboard: the three-entry shift register with advance/bubble/hold controls. Comparison and priority logic stays in the top.

## Test plan
- LD r3 followed by ADD r4,r3,r1 → one cycle of pc_hold=ifid_hold=idex_bubble=1. ADD then reaches EX with fwd_a=10.
- ADD r2 then SUB r5,r2,r2 back-to-back → no stall; SUB in EX sees fwd_a=fwd_b=01.
- BEQ taken (ex_branch_taken=1) while ID holds a load-use dependent instruction → ifid_flush=idex_bubble=1, pc_hold=0. flush_cnt+1, stall_cnt unchanged.
- dmem_busy high 3 cycles during a load-use hazard → holds for 3 cycles, no bubble. Then exactly one load-use stall cycle.
- ADDI r7 then ST r7,(r0) and NOP → ST gets fwd_b=01. NOP with id_rs1=7 causes no stall and fwd 00.
- rst_n pulsed low mid-stall → all outputs 0 immediately. Counters read 0 after release.

Source files
------------

// File: rtl/risc8_pkg.sv
// Shared definitions for the 8-bit RISC core: opcodes, forwarding encodings,
// hazard scoreboard entry type and the opcode-class decoder.
package risc8_pkg;

  localparam int RISC8_REG_AW = 4;
  localparam int RISC8_OPC_W  = 4;

  localparam logic [RISC8_OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [RISC8_OPC_W-1:0] OP_SUB  = 4'h1;
  localparam logic [RISC8_OPC_W-1:0] OP_AND  = 4'h2;
  localparam logic [RISC8_OPC_W-1:0] OP_OR   = 4'h3;
  localparam logic [RISC8_OPC_W-1:0] OP_ADDI = 4'h4;
  localparam logic [RISC8_OPC_W-1:0] OP_LD   = 4'h5;
  localparam logic [RISC8_OPC_W-1:0] OP_ST   = 4'h6;
  localparam logic [RISC8_OPC_W-1:0] OP_XOR  = 4'h7;
  localparam logic [RISC8_OPC_W-1:0] OP_BEQ  = 4'h8;
  localparam logic [RISC8_OPC_W-1:0] OP_SHLI = 4'h9;
  localparam logic [RISC8_OPC_W-1:0] OP_MOV  = 4'hA;
  localparam logic [RISC8_OPC_W-1:0] OP_NOT  = 4'hB;
  localparam logic [RISC8_OPC_W-1:0] OP_SLT  = 4'hC;
  localparam logic [RISC8_OPC_W-1:0] OP_SHL  = 4'hD;
  localparam logic [RISC8_OPC_W-1:0] OP_SHR  = 4'hE;
  localparam logic [RISC8_OPC_W-1:0] OP_NOP  = 4'hF;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                    valid;
    logic [RISC8_REG_AW-1:0] rd;
    logic                    regwrite;
    logic                    memread;
  } sb_entry_t;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic reads_rs1;
    logic reads_rs2;
  } op_class_t;

  function automatic op_class_t decode_op(input logic [RISC8_OPC_W-1:0] op);
    op_class_t c;
    c.regwrite  = 1'b1;
    c.memread   = (op == OP_LD);
    c.reads_rs1 = 1'b1;
    c.reads_rs2 = 1'b1;
    case (op)
      OP_ST, OP_BEQ:         c.regwrite  = 1'b0;
      OP_ADDI, OP_LD, OP_SHLI: c.reads_rs2 = 1'b0;
      OP_MOV, OP_NOT:        c.reads_rs1 = 1'b0;
      OP_NOP: begin
        c.regwrite  = 1'b0;
        c.reads_rs1 = 1'b0;
        c.reads_rs2 = 1'b0;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry (EX, MEM, WB) destination-register shift register.
// Shifts on advance; a bubble loads an invalid entry into EX.
module hazard_scoreboard
  import risc8_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      advance_i,
  input  logic      bubble_i,
  input  sb_entry_t id_entry_i,
  output sb_entry_t ex_entry_o,
  output sb_entry_t mem_entry_o,
  output sb_entry_t wb_entry_o
);

  sb_entry_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble_i ? '0 : id_entry_i;
    end
  end

  assign ex_entry_o  = ex_q;
  assign mem_entry_o = mem_q;
  assign wb_entry_o  = wb_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: freeze, branch squash, load-use stall, EX forwarding.
// Optional performance counters under HAZARD_PERF_CNT_EN.
module hazard_scheduler
  import risc8_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  op_class_t dec;
  sb_entry_t id_entry, ex_e, mem_e, wb_entry_unused;
  logic      use_rs1, use_rs2, load_use;
  logic      freeze, squash, stall;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_q, fwd_b_q;

  assign dec     = decode_op(id_opcode);
  assign use_rs1 = id_valid & dec.reads_rs1;
  assign use_rs2 = id_valid & dec.reads_rs2;

  assign id_entry.valid    = id_valid;
  assign id_entry.rd       = id_rd;
  assign id_entry.regwrite = id_valid & dec.regwrite;
  assign id_entry.memread  = id_valid & dec.memread;

  assign load_use = ex_e.valid & ex_e.memread &
                    ((use_rs1 & (id_rs1 == ex_e.rd)) | (use_rs2 & (id_rs2 == ex_e.rd)));

  assign freeze = dmem_busy;
  assign squash = ~freeze & ex_branch_taken;
  assign stall  = ~freeze & ~squash & load_use;

  assign pc_hold     = freeze | stall;
  assign ifid_hold   = freeze | stall;
  assign ifid_flush  = squash;
  assign idex_bubble = squash | stall;

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance_i   (~freeze),
    .bubble_i    (squash | stall),
    .id_entry_i  (id_entry),
    .ex_entry_o  (ex_e),
    .mem_entry_o (mem_e),
    .wb_entry_o  (wb_entry_unused)
  );

  // EX producer will sit in MEM next cycle, so it is checked first (youngest wins).
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                         input sb_entry_t ex_i, input sb_entry_t mem_i);
    if (!used)                                          return FWD_RF;
    else if (ex_i.valid && ex_i.regwrite && src == ex_i.rd)    return FWD_EXMEM;
    else if (mem_i.valid && mem_i.regwrite && src == mem_i.rd) return FWD_MEMWB;
    else                                                return FWD_RF;
  endfunction

  assign fwd_a_d = fwd_sel(use_rs1, id_rs1, ex_e, mem_e);
  assign fwd_b_d = fwd_sel(use_rs2, id_rs2, ex_e, mem_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!freeze) begin
      if (squash || stall) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (squash && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: table of per-cycle vectors plus a
// mid-stall reset sequence; expected fwd values go through a queue.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opcode, id_rd, id_rs1, id_rs2;
  logic       ex_branch_taken, dmem_busy;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rd           (id_rd),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  // ctrl = {pc_hold, ifid_hold, ifid_flush, idex_bubble}; fa/fb = fwd after this cycle's edge
  typedef struct packed {
    logic       v;
    logic [3:0] op, rd, rs1, rs2;
    logic       br, busy;
    logic [3:0] ctrl;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct packed {
    logic [1:0] a, b;
  } fwd_exp_t;

  localparam int NVEC = 28;
  vec_t     vecs[NVEC];
  fwd_exp_t fwd_q[$];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       exp_stall = 0;
  int       exp_flush = 0;

  function automatic vec_t mk(logic v, logic [3:0] op, logic [3:0] rd, logic [3:0] rs1,
                              logic [3:0] rs2, logic br, logic busy, logic [3:0] ctrl,
                              logic [1:0] fa, logic [1:0] fb);
    vec_t t;
    t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.br = br; t.busy = busy; t.ctrl = ctrl; t.fa = fa; t.fb = fb;
    return t;
  endfunction

  function automatic logic [15:0] cnt_exp(int n);
`ifdef HAZARD_PERF_CNT_EN
    return n[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_opcode = t.op; id_rd = t.rd; id_rs1 = t.rs1; id_rs2 = t.rs2;
    ex_branch_taken = t.br; dmem_busy = t.busy;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    fwd_exp_t e;
    drive(t);
    #2;
    check($sformatf("v%0d ctrl", idx), {pc_hold, ifid_hold, ifid_flush, idex_bubble}, t.ctrl);
    fwd_q.push_back({t.fa, t.fb});
    if (t.ctrl[0] && !t.ctrl[1]) exp_stall++;
    if (t.ctrl[1]) exp_flush++;
    @(posedge clk);
    #1;
    e = fwd_q.pop_front();
    check($sformatf("v%0d fwd_a", idx), fwd_a, e.a);
    check($sformatf("v%0d fwd_b", idx), fwd_b, e.b);
    check($sformatf("v%0d stall_cnt", idx), stall_cnt, cnt_exp(exp_stall));
    check($sformatf("v%0d flush_cnt", idx), flush_cnt, cnt_exp(exp_flush));
  endtask

  initial begin
    //           v  op  rd   rs1  rs2 br busy ctrl     fa fb
    vecs[0]  = mk(1, 4'h5, 4'd3, 4'd0, 4'd0, 0, 0, 4'b0000, 0, 0); // LD r3
    vecs[1]  = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 0, 0, 4'b1101, 0, 0); // ADD r4,r3,r1 stall
    vecs[2]  = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 0, 0, 4'b0000, 2, 0);
    vecs[3]  = mk(1, 4'h0, 4'd2, 4'd1, 4'd1, 0, 0, 4'b0000, 0, 0); // ADD r2
    vecs[4]  = mk(1, 4'h1, 4'd5, 4'd2, 4'd2, 0, 0, 4'b0000, 1, 1); // SUB r5,r2,r2
    vecs[5]  = mk(1, 4'h4, 4'd7, 4'd4, 4'd5, 0, 0, 4'b0000, 0, 0); // ADDI r7 (rs2 unread)
    vecs[6]  = mk(1, 4'h6, 4'd0, 4'd0, 4'd7, 0, 0, 4'b0000, 0, 1); // ST r7,(r0)
    vecs[7]  = mk(1, 4'hF, 4'd0, 4'd7, 4'd7, 0, 0, 4'b0000, 0, 0); // NOP
    vecs[8]  = mk(1, 4'h0, 4'd6, 4'd1, 4'd1, 0, 0, 4'b0000, 0, 0);
    vecs[9]  = mk(1, 4'h1, 4'd6, 4'd6, 4'd1, 0, 0, 4'b0000, 1, 0);
    vecs[10] = mk(1, 4'h3, 4'd1, 4'd6, 4'd6, 0, 0, 4'b0000, 1, 1); // youngest wins
    vecs[11] = mk(1, 4'hA, 4'd8, 4'd6, 4'd1, 0, 0, 4'b0000, 0, 1); // MOV rs2 only
    vecs[12] = mk(1, 4'h7, 4'd9, 4'd1, 4'd8, 0, 0, 4'b0000, 2, 1);
    vecs[13] = mk(1, 4'h5, 4'd3, 4'd0, 4'd0, 0, 0, 4'b0000, 0, 0); // LD r3
    vecs[14] = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 1, 0, 4'b0011, 0, 0); // branch beats load-use
    vecs[15] = mk(0, 4'h0, 4'd0, 4'd0, 4'd0, 0, 0, 4'b0000, 0, 0);
    vecs[16] = mk(1, 4'h0, 4'd9, 4'd1, 4'd1, 0, 0, 4'b0000, 0, 0);
    vecs[17] = mk(1, 4'h5, 4'd3, 4'd9, 4'd0, 0, 0, 4'b0000, 1, 0); // LD r3,(r9)
    vecs[18] = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 0, 1, 4'b1100, 1, 0); // freeze holds fwd
    vecs[19] = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 1, 1, 4'b1100, 1, 0); // freeze beats branch
    vecs[20] = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 0, 1, 4'b1100, 1, 0);
    vecs[21] = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 0, 0, 4'b1101, 0, 0); // one stall after freeze
    vecs[22] = mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 0, 0, 4'b0000, 2, 0);
    vecs[23] = mk(1, 4'h5, 4'd5, 4'd0, 4'd0, 0, 0, 4'b0000, 0, 0); // LD r5
    vecs[24] = mk(1, 4'h4, 4'd6, 4'd1, 4'd5, 0, 0, 4'b0000, 0, 0); // unread rs2 no stall
    vecs[25] = mk(1, 4'h5, 4'd5, 4'd0, 4'd0, 0, 0, 4'b0000, 0, 0);
    vecs[26] = mk(1, 4'hA, 4'd7, 4'd0, 4'd5, 0, 0, 4'b1101, 0, 0); // rs2 load-use
    vecs[27] = mk(1, 4'hA, 4'd7, 4'd0, 4'd5, 0, 0, 4'b0000, 0, 2);

    rst_n = 1'b0;
    drive(mk(0, 4'h0, 4'd0, 4'd0, 4'd0, 0, 0, 4'b0000, 0, 0));
    #2;
    check("reset ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble}, 4'b0000);
    check("reset fwd", {fwd_a, fwd_b}, 4'b0000);
    check("reset cnt", {stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Reset asserted in the middle of a load-use stall.
    run_vec(mk(1, 4'h5, 4'd3, 4'd0, 4'd0, 0, 0, 4'b0000, 0, 0), 100);
    drive(mk(1, 4'h0, 4'd4, 4'd3, 4'd1, 0, 0, 4'b0000, 0, 0));
    #2;
    check("pre-rst stall", {pc_hold, ifid_hold, ifid_flush, idex_bubble}, 4'b1101);
    rst_n = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    check("mid-rst ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble}, 4'b0000);
    check("mid-rst fwd", {fwd_a, fwd_b}, 4'b0000);
    check("mid-rst cnt", {stall_cnt, flush_cnt}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble}, 4'b0000);
    @(posedge clk);
    #1;
    check("post-rst fwd", {fwd_a, fwd_b}, 4'b0000);
    check("post-rst cnt", {stall_cnt, flush_cnt}, {cnt_exp(exp_stall), cnt_exp(exp_flush)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
